game_ctrl_fsm: RTL and testbench
================================

// Module: game_ctrl_fsm
// PURPOSE
//  Parametrised top-level Minesweeper game controller. Sequences first-cell pick, mine placement, start reveal,
//  play, win/lose and replay for any board size. Adds multi-life play, pause, game timer with time limit, and
//  handshake watchdogs on the mine placer and start-reveal units. Sits between input debouncers and board/display.
// PARAMETERS
//  ADDR_W     8     cell address width (board up to 2**ADDR_W cells)
//  LIVES      1     mine hits tolerated before loss (1..15)
//  SEC_W      10    width of elapsed-seconds counter
//  TIME_LIMIT 999   seconds allowed in play; 0 = unlimited
//  HS_TIMEOUT 4096  cycles allowed for mine_done / start_done before ERROR
// PORTS
//  clk              in  1       system clock
//  rst              in  1       async reset, active-low
//  go               in  1       leave IDLE
//  sel              in  1       select pulse (first cell pick)
//  cursor_addr      in  ADDR_W  cursor cell
//  mine_done        in  1       mine placer finished
//  start_done       in  1       start-region reveal finished
//  cond             in  2       board status: 0 none, 1 win, 2 mine hit, 3 ignored
//  pause            in  1       level; freeze play while high
//  tick_1hz         in  1       one-cycle enable per second
//  play_again       in  1       replay request
//  mine_start       out 1       high in MINE_PLACE
//  start_en         out 1       high in SEL_START
//  play_en          out 1       high in PLAY only
//  board_clr        out 1       one-cycle pulse in RST_BOARD
//  done             out 1       one-cycle pulse in WIN_S/LOSE_S
//  result           out 2       registered: 0 none, 1 win, 2 lost-mine, 3 lost-timeout
//  start_cell_addr  out ADDR_W  latched first pick
//  lives_left       out 4       remaining lives
//  elapsed_sec      out SEC_W   seconds played (saturating)
//  err              out 1       high in ERROR
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except lives_left=LIVES.
//  States: IDLE, WAIT_SEL, MINE_PLACE, SEL_START, PLAY, PAUSED, HIT, WIN_S, LOSE_S, IF_PLAY_AGAIN, RST_BOARD, ERROR.
//  IDLE->WAIT_SEL on go. WAIT_SEL->MINE_PLACE on sel; same edge latches start_cell_addr<=cursor_addr (only here).
//  MINE_PLACE->SEL_START on mine_done; SEL_START->PLAY on start_done. Watchdog counter clears on entering each;
//   reaching HS_TIMEOUT cycles without done -> ERROR. done arriving on the timeout cycle wins (no ERROR).
//  PLAY priority per cycle: cond==1 -> WIN_S; else cond==2 -> HIT; else timeout -> LOSE_S; else pause -> PAUSED.
//  HIT (1 cycle): lives_left decrements; if it was 1 -> LOSE_S result 2, else -> PLAY. cond ignored in HIT.
//  PAUSED: timer frozen, cond ignored, play_en low; ->PLAY when pause low.
//  Timer: elapsed_sec increments on tick_1hz only in PLAY; saturates at all-ones. Timeout when TIME_LIMIT!=0 and
//   elapsed_sec>=TIME_LIMIT -> LOSE_S, result 3.
//  WIN_S/LOSE_S: one cycle, done=1, result registered, ->IF_PLAY_AGAIN. result/elapsed_sec hold until RST_BOARD.
//  IF_PLAY_AGAIN->RST_BOARD on play_again. ERROR->RST_BOARD on play_again (result stays 0).
//  RST_BOARD (1 cycle): board_clr=1; clears result, elapsed_sec, start_cell_addr; lives_left<=LIVES; ->WAIT_SEL.
//  Illegal state encoding -> ERROR. Reset mid-game returns to IDLE with no done pulse.
// STRUCTURE
//  Package game_pkg: state enum, result codes (RES_NONE/WIN/MINE/TIME), cond codes.
//  Sub-module game_timer: tick-gated saturating seconds counter with clear, enable, limit compare -> timeout.
//  Watchdog and lives counter inline in game_ctrl_fsm.
// TESTING
//  go, sel@addr 0x37, mine_done after 10, start_done after 5, cond=1 -> start_cell_addr=0x37, done 1 cycle, result=1.
//  LIVES=3: three cond=2 pulses in PLAY -> lives 2,1 then LOSE_S, result=2; first two return to PLAY.
//  TIME_LIMIT=5: 5 ticks in PLAY -> LOSE_S, result=3; ticks during pause high do not advance elapsed_sec.
//  mine_done withheld HS_TIMEOUT cycles -> err=1; play_again -> board_clr pulse, WAIT_SEL, err=0.
//  cond=1 on same cycle as timeout -> result=1; cond=2 while PAUSED -> lives unchanged.
//  rst low mid-PLAY -> IDLE, result=0, elapsed_sec=0, lives_left=LIVES, no done pulse.

Source files
------------

// File: rtl/game_ctrl_fsm_pkg.sv
// Shared types for the Minesweeper game controller: FSM states, result and board-condition codes.
// No logic, no latency.
// No flow control; types only.
package game_pkg;

  // Controller states; 12 codes in 4 bits, the unused codes are treated as illegal.
  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_WAIT_SEL      = 4'd1,
    ST_MINE_PLACE    = 4'd2,
    ST_SEL_START     = 4'd3,
    ST_PLAY          = 4'd4,
    ST_PAUSED        = 4'd5,
    ST_HIT           = 4'd6,
    ST_WIN_S         = 4'd7,
    ST_LOSE_S        = 4'd8,
    ST_IF_PLAY_AGAIN = 4'd9,
    ST_RST_BOARD     = 4'd10,
    ST_ERROR         = 4'd11
  } state_t;

  // Game outcome as presented on the result port.
  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_WIN  = 2'd1,
    RES_MINE = 2'd2,
    RES_TIME = 2'd3
  } result_t;

  // Board status reported by the board logic each cycle.
  typedef enum logic [1:0] {
    COND_NONE   = 2'd0,
    COND_WIN    = 2'd1,
    COND_MINE   = 2'd2,
    COND_IGNORE = 2'd3
  } cond_t;

  // Handshake states are the ones guarded by the watchdog.
  function automatic logic is_handshake(state_t s);
    return (s == ST_MINE_PLACE) || (s == ST_SEL_START);
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Bundles the controller's player/board inputs and control/status outputs.
// No logic, no latency.
// Level/pulse signalling only; no backpressure on any signal.
interface game_ctrl_fsm_if #(
  parameter int ADDR_W = 8,
  parameter int SEC_W  = 10
);

  // Inputs to the controller
  logic              go;
  logic              sel;
  logic [ADDR_W-1:0] cursor_addr;
  logic              mine_done;
  logic              start_done;
  logic [1:0]        cond;
  logic              pause;
  logic              tick_1hz;
  logic              play_again;

  // Outputs from the controller
  logic              mine_start;
  logic              start_en;
  logic              play_en;
  logic              board_clr;
  logic              done;
  logic [1:0]        result;
  logic [ADDR_W-1:0] start_cell_addr;
  logic [3:0]        lives_left;
  logic [SEC_W-1:0]  elapsed_sec;
  logic              err;

  // Side that drives the player/board inputs and observes status
  modport master (
    output go, sel, cursor_addr, mine_done, start_done, cond, pause, tick_1hz, play_again,
    input  mine_start, start_en, play_en, board_clr, done, result, start_cell_addr,
           lives_left, elapsed_sec, err
  );

  // The controller itself
  modport slave (
    input  go, sel, cursor_addr, mine_done, start_done, cond, pause, tick_1hz, play_again,
    output mine_start, start_en, play_en, board_clr, done, result, start_cell_addr,
           lives_left, elapsed_sec, err
  );

endinterface

// File: rtl/game_ctrl_fsm_timer.sv
// Game timer: saturating seconds counter advanced by a 1 Hz tick while enabled, with limit compare.
// elapsed_sec updates one cycle after an enabled tick; timeout is combinational from the count.
// No backpressure; ticks arriving while disabled are dropped.
module game_timer #(
  parameter int          SEC_W      = 10,
  parameter int unsigned TIME_LIMIT = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  output logic [SEC_W-1:0] elapsed_sec,
  output logic             timeout
);

  localparam logic [SEC_W-1:0] SEC_MAX = '1;

  logic [SEC_W-1:0] sec_q;

  // Count enabled ticks, holding at all-ones; clear wins over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q <= '0;
    end else if (clr) begin
      sec_q <= '0;
    end else if (en && tick && (sec_q != SEC_MAX)) begin
      sec_q <= sec_q + SEC_W'(1);
    end
  end

  assign elapsed_sec = sec_q;

  // A zero limit means unlimited play; compare at 32 bits so any limit value is honoured.
  assign timeout = (TIME_LIMIT != 0) && (32'(sec_q) >= TIME_LIMIT);

endmodule

// File: rtl/game_ctrl_fsm.sv
// Minesweeper game controller: first pick, mine placement, start reveal, play with lives/pause/timer, replay.
// Moore outputs decoded from the state register; status registers update on the transition edge.
// No backpressure; mine placer and start-reveal handshakes are guarded by a cycle watchdog.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          LIVES      = 1,
  parameter int          SEC_W      = 10,
  parameter int unsigned TIME_LIMIT = 999,
  parameter int unsigned HS_TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  game_ctrl_fsm_if.slave bus
);

  localparam int          WD_W       = $clog2(HS_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(HS_TIMEOUT - 1);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);

  state_t            state_q, state_d;
  result_t           result_q, result_d;
  logic [3:0]        lives_q, lives_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WD_W-1:0]   wd_q;
  logic              wd_expired;
  logic              timer_timeout;
  logic [SEC_W-1:0]  timer_sec;
  cond_t             cond_in;

  assign cond_in    = cond_t'(bus.cond);
  assign wd_expired = (wd_q == WD_LAST);

  game_timer #(
    .SEC_W      (SEC_W),
    .TIME_LIMIT (TIME_LIMIT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_q == ST_RST_BOARD),
    .en          (state_q == ST_PLAY),
    .tick        (bus.tick_1hz),
    .elapsed_sec (timer_sec),
    .timeout     (timer_timeout)
  );

  // State and status registers; reset returns to IDLE with a full set of lives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      result_q <= RES_NONE;
      lives_q  <= LIVES_INIT;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      lives_q  <= lives_d;
      addr_q   <= addr_d;
    end
  end

  // Watchdog restarts on every state change and only runs in the handshake states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else if (is_handshake(state_q) && !wd_expired) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // Next-state and status-register update logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    lives_d  = lives_q;
    addr_d   = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.go) state_d = ST_WAIT_SEL;
      end
      ST_WAIT_SEL: begin
        if (bus.sel) begin
          state_d = ST_MINE_PLACE;
          addr_d  = bus.cursor_addr;
        end
      end
      ST_MINE_PLACE: begin
        // A done arriving on the last allowed cycle still counts.
        if (bus.mine_done)   state_d = ST_SEL_START;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_SEL_START: begin
        if (bus.start_done)  state_d = ST_PLAY;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_PLAY: begin
        // Win beats a mine hit, which beats the time limit, which beats pause.
        if (cond_in == COND_WIN) begin
          state_d  = ST_WIN_S;
          result_d = RES_WIN;
        end else if (cond_in == COND_MINE) begin
          state_d = ST_HIT;
        end else if (timer_timeout) begin
          state_d  = ST_LOSE_S;
          result_d = RES_TIME;
        end else if (bus.pause) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!bus.pause) state_d = ST_PLAY;
      end
      ST_HIT: begin
        lives_d = lives_q - 4'd1;
        if (lives_q <= 4'd1) begin
          state_d  = ST_LOSE_S;
          result_d = RES_MINE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_WIN_S, ST_LOSE_S: begin
        state_d = ST_IF_PLAY_AGAIN;
      end
      ST_IF_PLAY_AGAIN, ST_ERROR: begin
        if (bus.play_again) state_d = ST_RST_BOARD;
      end
      ST_RST_BOARD: begin
        state_d  = ST_WAIT_SEL;
        result_d = RES_NONE;
        lives_d  = LIVES_INIT;
        addr_d   = '0;
      end
      default: begin
        // Corrupted encoding: park in ERROR until the player asks for a new game.
        state_d = ST_ERROR;
      end
    endcase
  end

  // Moore control outputs decoded from the current state.
  always_comb begin
    bus.mine_start = (state_q == ST_MINE_PLACE);
    bus.start_en   = (state_q == ST_SEL_START);
    bus.play_en    = (state_q == ST_PLAY);
    bus.board_clr  = (state_q == ST_RST_BOARD);
    bus.done       = (state_q == ST_WIN_S) || (state_q == ST_LOSE_S);
    bus.err        = (state_q == ST_ERROR);
  end

  assign bus.result          = result_q;
  assign bus.start_cell_addr = addr_q;
  assign bus.lives_left      = lives_q;
  assign bus.elapsed_sec     = timer_sec;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm: directed scenarios with literal expectations plus random play
// checked every cycle against a game-level reference model.
module tb_game_ctrl_fsm;

  localparam int ADDR_W     = 8;
  localparam int LIVES      = 3;
  localparam int SEC_W      = 10;
  localparam int TIME_LIMIT = 5;
  localparam int HS_TIMEOUT = 64;
  localparam int SEC_MAX    = (1 << SEC_W) - 1;

  // Model phases (game-level view; win and loss share one "game over" phase)
  localparam int P_IDLE = 0, P_PICK = 1, P_MINES = 2, P_REVEAL = 3, P_PLAY = 4, P_FROZEN = 5;
  localparam int P_HIT = 6, P_OVER = 7, P_ASK = 8, P_CLEAR = 9, P_FAULT = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_ctrl_fsm_if #(.ADDR_W(ADDR_W), .SEC_W(SEC_W)) gif ();

  game_ctrl_fsm #(
    .ADDR_W     (ADDR_W),
    .LIVES      (LIVES),
    .SEC_W      (SEC_W),
    .TIME_LIMIT (TIME_LIMIT),
    .HS_TIMEOUT (HS_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase = P_IDLE;
  int m_lives = LIVES;
  int m_sec   = 0;
  int m_res   = 0;
  int m_addr  = 0;
  int m_wait  = 0;
  int m_nxt;
  bit m_expired;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_lives = LIVES; m_sec = 0; m_res = 0; m_addr = 0; m_wait = 0;
    end else begin
      m_nxt = m_phase;
      case (m_phase)
        P_IDLE:  if (gif.go) m_nxt = P_PICK;
        P_PICK:  if (gif.sel) begin m_addr = int'(gif.cursor_addr); m_nxt = P_MINES; end
        P_MINES: begin
          m_wait++;
          if (gif.mine_done) m_nxt = P_REVEAL;
          else if (m_wait >= HS_TIMEOUT) m_nxt = P_FAULT;
        end
        P_REVEAL: begin
          m_wait++;
          if (gif.start_done) m_nxt = P_PLAY;
          else if (m_wait >= HS_TIMEOUT) m_nxt = P_FAULT;
        end
        P_PLAY: begin
          m_expired = (TIME_LIMIT != 0) && (m_sec >= TIME_LIMIT);
          if (gif.cond == 2'd1) begin m_res = 1; m_nxt = P_OVER; end
          else if (gif.cond == 2'd2) m_nxt = P_HIT;
          else if (m_expired) begin m_res = 3; m_nxt = P_OVER; end
          else if (gif.pause) m_nxt = P_FROZEN;
          if (gif.tick_1hz && m_sec < SEC_MAX) m_sec++;
        end
        P_FROZEN: if (!gif.pause) m_nxt = P_PLAY;
        P_HIT: begin
          m_lives--;
          if (m_lives == 0) begin m_res = 2; m_nxt = P_OVER; end
          else m_nxt = P_PLAY;
        end
        P_OVER:         m_nxt = P_ASK;
        P_ASK, P_FAULT: if (gif.play_again) m_nxt = P_CLEAR;
        P_CLEAR: begin
          m_res = 0; m_sec = 0; m_addr = 0; m_lives = LIVES; m_nxt = P_PICK;
        end
        default: m_nxt = P_FAULT;
      endcase
      if (m_nxt != m_phase) m_wait = 0;
      m_phase = m_nxt;
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("mine_start", gif.mine_start, m_phase == P_MINES);
    chk("start_en",   gif.start_en,   m_phase == P_REVEAL);
    chk("play_en",    gif.play_en,    m_phase == P_PLAY);
    chk("board_clr",  gif.board_clr,  m_phase == P_CLEAR);
    chk("done",       gif.done,       m_phase == P_OVER);
    chk("err",        gif.err,        m_phase == P_FAULT);
    chk("result",     gif.result,     m_res);
    chk("start_cell", gif.start_cell_addr, m_addr);
    chk("lives_left", gif.lives_left, m_lives);
    chk("elapsed",    gif.elapsed_sec, m_sec);
    if (gif.done) n_done++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    gif.go = 1'b0; gif.sel = 1'b0; gif.cursor_addr = '0; gif.mine_done = 1'b0;
    gif.start_done = 1'b0; gif.cond = 2'd0; gif.pause = 1'b0; gif.tick_1hz = 1'b0;
    gif.play_again = 1'b0;
  endtask

  // From IDLE or WAIT_SEL: pick a cell, place mines after 10 cycles, reveal after 5; ends in PLAY.
  task automatic start_game(input logic [ADDR_W-1:0] a);
    gif.go = 1'b1; step(1); gif.go = 1'b0;
    gif.sel = 1'b1; gif.cursor_addr = a; step(1);
    gif.sel = 1'b0; gif.cursor_addr = 8'hFF;
    step(10); gif.mine_done = 1'b1; step(1); gif.mine_done = 1'b0;
    step(5);  gif.start_done = 1'b1; step(1); gif.start_done = 1'b0;
  endtask

  task automatic new_round(input string tag);
    gif.play_again = 1'b1; step(1);
    chk({tag, "_board_clr"}, gif.board_clr, 1);
    gif.play_again = 1'b0; step(1);
    chk({tag, "_clr_result"}, gif.result, 0);
    chk({tag, "_clr_lives"}, gif.lives_left, LIVES);
  endtask

  int done_before;
  int done_pct;
  int r;

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_lives", gif.lives_left, LIVES);
    chk("rst_result", gif.result, 0);
    chk("rst_err", gif.err, 0);
    chk("rst_play_en", gif.play_en, 0);
    step(2);
    rst = 1'b1;
    step(1);

    // Win with a latched first pick
    start_game(8'h37);
    chk("s1_play_en", gif.play_en, 1);
    chk("s1_addr", gif.start_cell_addr, 8'h37);
    gif.cond = 2'd1; step(1); gif.cond = 2'd0;
    chk("s1_done", gif.done, 1);
    chk("s1_result", gif.result, 1);
    step(1);
    chk("s1_done_once", gif.done, 0);
    chk("s1_result_hold", gif.result, 1);
    new_round("s1");
    chk("s1_addr_clr", gif.start_cell_addr, 0);

    // Three mine hits with three lives
    start_game(8'h12);
    for (int i = 1; i <= 2; i++) begin
      gif.cond = 2'd2; step(1); gif.cond = 2'd0; step(1);
      chk("s2_lives", gif.lives_left, LIVES - i);
      chk("s2_back_play", gif.play_en, 1);
    end
    gif.cond = 2'd2; step(1); gif.cond = 2'd0; step(1);
    chk("s2_lose_done", gif.done, 1);
    chk("s2_result", gif.result, 2);
    step(1);
    new_round("s2");

    // Pause freezes timer and ignores cond; then time limit expires
    start_game(8'h05);
    gif.pause = 1'b1; step(1);
    chk("s3_paused_play_en", gif.play_en, 0);
    gif.tick_1hz = 1'b1; gif.cond = 2'd2; step(3);
    chk("s3_paused_sec", gif.elapsed_sec, 0);
    chk("s3_paused_lives", gif.lives_left, LIVES);
    gif.pause = 1'b0; gif.cond = 2'd0; gif.tick_1hz = 1'b0; step(1);
    chk("s3_resume", gif.play_en, 1);
    gif.tick_1hz = 1'b1; step(5); gif.tick_1hz = 1'b0;
    chk("s3_sec5", gif.elapsed_sec, 5);
    step(1);
    chk("s3_done", gif.done, 1);
    chk("s3_result", gif.result, 3);
    step(1);
    chk("s3_sec_hold", gif.elapsed_sec, 5);
    new_round("s3");
    chk("s3_sec_clr", gif.elapsed_sec, 0);

    // Win on the same cycle the time limit is reached
    start_game(8'hA0);
    gif.tick_1hz = 1'b1; step(5); gif.tick_1hz = 1'b0;
    gif.cond = 2'd1; step(1); gif.cond = 2'd0;
    chk("s4_result", gif.result, 1);
    step(1);
    new_round("s4");

    // Mine placer watchdog
    gif.sel = 1'b1; gif.cursor_addr = 8'h44; step(1); gif.sel = 1'b0;
    step(HS_TIMEOUT - 1);
    chk("s5_still_placing", gif.mine_start, 1);
    step(1);
    chk("s5_err", gif.err, 1);
    chk("s5_err_result", gif.result, 0);
    new_round("s5");
    chk("s5_err_clr", gif.err, 0);

    // Done on the last allowed cycle wins; then start-reveal watchdog
    gif.sel = 1'b1; step(1); gif.sel = 1'b0;
    step(HS_TIMEOUT - 1);
    gif.mine_done = 1'b1; step(1); gif.mine_done = 1'b0;
    chk("s6_late_done_ok", gif.start_en, 1);
    step(HS_TIMEOUT - 1);
    chk("s6_reveal_wait", gif.err, 0);
    step(1);
    chk("s6_reveal_err", gif.err, 1);
    new_round("s6");

    // Reset in the middle of play
    start_game(8'h21);
    gif.tick_1hz = 1'b1; step(2); gif.tick_1hz = 1'b0;
    chk("s7_sec2", gif.elapsed_sec, 2);
    done_before = n_done;
    #3 rst = 1'b0;
    #1;
    chk("s7_rst_result", gif.result, 0);
    chk("s7_rst_sec", gif.elapsed_sec, 0);
    chk("s7_rst_lives", gif.lives_left, LIVES);
    chk("s7_rst_play_en", gif.play_en, 0);
    step(2);
    rst = 1'b1;
    step(2);
    chk("s7_no_done", n_done, done_before);
    chk("s7_idle", gif.mine_start | gif.play_en | gif.err, 0);

    // Random play against the model
    done_pct = 15;
    for (int c = 0; c < 6000; c++) begin
      if (c % 200 == 0) begin
        r = $urandom_range(0, 2);
        done_pct = (r == 0) ? 2 : (r == 1) ? 15 : 50;
      end
      gif.go          = ($urandom_range(0, 3) == 0);
      gif.sel         = ($urandom_range(0, 3) == 0);
      gif.cursor_addr = ADDR_W'($urandom);
      gif.mine_done   = ($urandom_range(0, 99) < done_pct);
      gif.start_done  = ($urandom_range(0, 99) < done_pct);
      r = $urandom_range(0, 99);
      gif.cond        = (r < 84) ? 2'd0 : (r < 89) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 9) == 0) gif.pause = ~gif.pause;
      gif.tick_1hz    = ($urandom_range(0, 2) == 0);
      gif.play_again  = ($urandom_range(0, 4) == 0);
      rst             = ($urandom_range(0, 399) != 0);
      step(1);
    end

    idle_inputs();
    rst = 1'b1;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
